// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with a prefetch queue
// Issues sequential I-cache reads and buffers {instruction, pc} pairs for decode.
module fetch_unit #(
    parameter int unsigned         XLEN     = 32,
    parameter int unsigned         DEPTH    = 4,
    parameter logic [XLEN-1:0]     RESET_PC = '0
) (
    input  logic                             CLK,
    input  logic                             RESET,
    output logic                             insReadEn,
    output logic [XLEN-1:0]                  INS_ADDR,
    input  logic [31:0]                      INSTRUCTION,
    input  logic                             INS_CACHE_BUSY_WAIT,
    input  logic                             REDIRECT_EN,
    input  logic [XLEN-1:0]                  REDIRECT_PC,
    input  logic                             FETCH_READY,
    output logic                             FETCH_VALID,
    output logic [31:0]                      FETCH_INSTRUCTION,
    output logic [XLEN-1:0]                  FETCH_PC,
    output logic [$clog2(DEPTH+1)-1:0]       QUEUE_COUNT
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [31:0]   NOP      = 32'h0000_0013;

    logic [XLEN-1:0] pc_q, pc_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     ins_mem_q [DEPTH];
    logic [31:0]     ins_mem_d [DEPTH];
    logic [XLEN-1:0] pc_mem_q  [DEPTH];
    logic [XLEN-1:0] pc_mem_d  [DEPTH];

    logic queue_full;
    logic queue_empty;
    logic fill_en;
    logic pop_en;

    always_comb begin
        queue_full  = (count_q == FULL_CNT);
        queue_empty = (count_q == '0);
        insReadEn   = !RESET && !REDIRECT_EN && !queue_full;
        fill_en     = insReadEn && !INS_CACHE_BUSY_WAIT;
        pop_en      = !RESET && !REDIRECT_EN && !queue_empty && FETCH_READY;
    end

    always_comb begin
        pc_d      = pc_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        ins_mem_d = ins_mem_q;
        pc_mem_d  = pc_mem_q;

        if (RESET) begin
            pc_d     = RESET_PC;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else if (REDIRECT_EN) begin
            // Redirect flushes everything; low address bits are forced to word alignment.
            pc_d     = REDIRECT_PC & ~XLEN'(3);
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (fill_en) begin
                ins_mem_d[wr_ptr_q] = INSTRUCTION;
                pc_mem_d[wr_ptr_q]  = pc_q;
                wr_ptr_d            = wr_ptr_q + PW'(1);
                pc_d                = pc_q + XLEN'(4);
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({fill_en, pop_en})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage carries no reset; occupancy is tracked by count_q alone.
    always_ff @(posedge CLK) begin
        ins_mem_q <= ins_mem_d;
        pc_mem_q  <= pc_mem_d;
    end

    always_comb begin
        INS_ADDR          = pc_q;
        QUEUE_COUNT       = count_q;
        FETCH_VALID       = !RESET && !queue_empty;
        FETCH_INSTRUCTION = queue_empty ? NOP   : ins_mem_q[rd_ptr_q];
        FETCH_PC          = queue_empty ? '0    : pc_mem_q[rd_ptr_q];
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic            CLK = 1'b0;
    logic            RESET;
    logic            insReadEn;
    logic [31:0]     INS_ADDR;
    logic [31:0]     INSTRUCTION;
    logic            INS_CACHE_BUSY_WAIT;
    logic            REDIRECT_EN;
    logic [31:0]     REDIRECT_PC;
    logic            FETCH_READY;
    logic            FETCH_VALID;
    logic [31:0]     FETCH_INSTRUCTION;
    logic [31:0]     FETCH_PC;
    logic [CW-1:0]   QUEUE_COUNT;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] ins_of(input logic [31:0] a);
        return {a[17:2], 16'hA0B3};
    endfunction

    // Cache model: garbage on the data bus while stalled.
    assign INSTRUCTION = INS_CACHE_BUSY_WAIT ? 32'hDEAD_BEEF : ins_of(INS_ADDR);

    fetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) u_dut (
        .CLK                 (CLK),
        .RESET               (RESET),
        .insReadEn           (insReadEn),
        .INS_ADDR            (INS_ADDR),
        .INSTRUCTION         (INSTRUCTION),
        .INS_CACHE_BUSY_WAIT (INS_CACHE_BUSY_WAIT),
        .REDIRECT_EN         (REDIRECT_EN),
        .REDIRECT_PC         (REDIRECT_PC),
        .FETCH_READY         (FETCH_READY),
        .FETCH_VALID         (FETCH_VALID),
        .FETCH_INSTRUCTION   (FETCH_INSTRUCTION),
        .FETCH_PC            (FETCH_PC),
        .QUEUE_COUNT         (QUEUE_COUNT)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    ent_t        sb[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_pc;
    int          m_cnt;
    bit          m_valid  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One cycle: drive inputs, check mid-cycle against the expected model, advance the model.
    task automatic step(input bit rst, input bit busy, input bit ready, input bit redir,
                        input logic [31:0] rpc);
        bit ren;
        bit fill;
        bit pop;
        RESET               = rst;
        INS_CACHE_BUSY_WAIT = busy;
        FETCH_READY         = ready;
        REDIRECT_EN         = redir;
        REDIRECT_PC         = rpc;
        @(negedge CLK);
        ren = !rst && !redir && (m_cnt < DEPTH);
        if (m_valid) begin
            chk("ins_addr",    INS_ADDR,    m_pc);
            chk("ins_read_en", insReadEn,   ren);
            chk("queue_count", QUEUE_COUNT, m_cnt);
            chk("fetch_valid", FETCH_VALID, (!rst && m_cnt != 0));
        end
        if (rst) begin
            m_pc    = 32'h0;
            m_cnt   = 0;
            m_valid = 1'b1;
            sb.delete();
        end else if (redir) begin
            m_pc  = {rpc[31:2], 2'b00};
            m_cnt = 0;
            sb.delete();
        end else begin
            fill = ren && !busy;
            pop  = (m_cnt != 0) && ready;
            if (fill) begin
                sb.push_back('{pc: m_pc, ins: ins_of(m_pc)});
                m_pc = m_pc + 32'd4;
            end
            m_cnt = m_cnt + int'(fill) - int'(pop);
        end
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (m_valid && !RESET && !REDIRECT_EN) begin
            if (FETCH_VALID) begin
                if (FETCH_READY) begin
                    if (sb.size() == 0) begin
                        chk("pop_unexpected", 1, 0);
                    end else begin
                        ent_t e;
                        e = sb.pop_front();
                        chk("pop_pc",  FETCH_PC,          e.pc);
                        chk("pop_ins", FETCH_INSTRUCTION, e.ins);
                    end
                end
            end else begin
                chk("empty_ins", FETCH_INSTRUCTION, 32'h0000_0013);
                chk("empty_pc",  FETCH_PC,          32'h0);
            end
        end
    end

    initial begin
        RESET = 1'b1; INS_CACHE_BUSY_WAIT = 1'b0; FETCH_READY = 1'b0;
        REDIRECT_EN = 1'b0; REDIRECT_PC = '0;

        step(1, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);

        step(0, 0, 1, 0, 0);
        chk("cold_addr1", INS_ADDR, 32'h4);
        chk("cold_cnt1",  QUEUE_COUNT, 1);
        chk("cold_ins1",  FETCH_INSTRUCTION, 32'h0000_A0B3);
        step(0, 0, 1, 0, 0);
        chk("cold_addr2", INS_ADDR, 32'h8);
        chk("cold_fpc2",  FETCH_PC, 32'h4);
        step(0, 0, 1, 0, 0);
        chk("cold_addr3", INS_ADDR, 32'hC);
        chk("cold_fpc3",  FETCH_PC, 32'h8);

        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        chk("full_cnt",  QUEUE_COUNT, 4);
        chk("full_addr", INS_ADDR, 32'h10);
        step(0, 0, 0, 0, 0);
        chk("full_hold_addr", INS_ADDR, 32'h10);
        step(0, 0, 1, 0, 0);
        chk("full_pop_cnt",  QUEUE_COUNT, 3);
        chk("full_pop_addr", INS_ADDR, 32'h10);
        step(0, 0, 0, 0, 0);
        chk("refill_cnt",  QUEUE_COUNT, 4);
        chk("refill_addr", INS_ADDR, 32'h14);
        chk("refill_fpc",  FETCH_PC, 32'h4);

        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        chk("busy_addr", INS_ADDR, 32'h8);
        chk("busy_cnt",  QUEUE_COUNT, 2);
        step(0, 0, 0, 0, 0);
        chk("busy_rel_addr", INS_ADDR, 32'hC);
        chk("busy_rel_cnt",  QUEUE_COUNT, 3);

        step(0, 0, 1, 1, 32'h103);
        chk("redir_cnt",   QUEUE_COUNT, 0);
        chk("redir_valid", FETCH_VALID, 0);
        chk("redir_addr",  INS_ADDR, 32'h100);
        step(0, 0, 1, 1, 32'h200);
        step(0, 1, 1, 1, 32'h306);
        chk("redir2_addr", INS_ADDR, 32'h304);

        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("ovl_pre_cnt", QUEUE_COUNT, 2);
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 1, 0, 0);
            chk("ovl_cnt", QUEUE_COUNT, 2);
        end
        chk("ovl_addr", INS_ADDR, 32'h324);
        chk("ovl_fpc",  FETCH_PC, 32'h31C);

        step(0, 0, 1, 1, 32'hFFFF_FFF9);
        chk("wrap_addr0", INS_ADDR, 32'hFFFF_FFF8);
        step(0, 0, 1, 0, 0);
        chk("wrap_addr1", INS_ADDR, 32'hFFFF_FFFC);
        step(0, 0, 1, 0, 0);
        chk("wrap_addr2", INS_ADDR, 32'h0);
        step(0, 0, 1, 0, 0);
        chk("wrap_addr3", INS_ADDR, 32'h4);
        chk("wrap_ins",   FETCH_INSTRUCTION, 32'h0000_A0B3);

        step(0, 1, 0, 0, 0);
        chk("miss_addr", INS_ADDR, 32'h4);
        chk("miss_cnt",  QUEUE_COUNT, 1);
        step(1, 1, 1, 0, 0);
        chk("rstmiss_addr", INS_ADDR, 32'h0);
        chk("rstmiss_cnt",  QUEUE_COUNT, 0);
        step(0, 0, 1, 0, 0);
        chk("rstmiss_next", INS_ADDR, 32'h4);
        chk("rstmiss_ins",  FETCH_INSTRUCTION, 32'h0000_A0B3);

        for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0);
        chk("drain_cnt", QUEUE_COUNT, 0);
        chk("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
